// File: rtl/sub_div4_ctrl.sv
// Restoring-division controller that issues one shared WIDTH-bit trial subtraction per clock.
// Optional SUB_DIV_DZ_EN: divide-by-zero short-cut to DONE with a sticky dz_err flag.
module sub_div4_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] div_reg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] trial;
    logic             top;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             qbit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;

    logic             load_ops;
    logic             step;
    logic             load_res;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    // One restoring step: shift, trial-subtract on the shared subtractor, accept or restore.
    always_comb begin
        trial       = {part_rem[WIDTH-2:0], shift_q[WIDTH-1]};
        top         = part_rem[WIDTH-1];
        {bout, diff} = {1'b0, trial} - {1'b0, div_reg};
        qbit        = top | ~bout;
        rem_step    = qbit ? diff : trial;
        q_step      = {shift_q[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef SUB_DIV_DZ_EN
                    state_next = (divisor == '0) ? DONE : RUN;
`else
                    state_next = RUN;
`endif
                end
            end
            RUN:     if (cnt == LAST_ITER) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result load happens on the edge entering DONE, so it captures the final step's values.
    always_comb begin
        load_ops = (state == IDLE) && start;
        step     = (state == RUN);
        load_res = (state_next == DONE);
        res_q    = q_step;
        res_r    = rem_step;
`ifdef SUB_DIV_DZ_EN
        if (state == IDLE) begin
            res_q = '1;
            res_r = dividend;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_rem <= '0;
            shift_q  <= '0;
            div_reg  <= '0;
            cnt      <= '0;
        end else if (load_ops) begin
            part_rem <= '0;
            shift_q  <= dividend;
            div_reg  <= divisor;
            cnt      <= '0;
        end else if (step) begin
            part_rem <= rem_step;
            shift_q  <= q_step;
            cnt      <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= load_res;
            if (load_res) begin
                quotient  <= res_q;
                remainder <= res_r;
            end
        end
    end

`ifdef SUB_DIV_DZ_EN
    // Only a divide-by-zero start reaches DONE straight from IDLE; every other DONE clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_err <= 1'b0;
        end else if (load_res) begin
            dz_err <= (state == IDLE);
        end
    end
`else
    assign dz_err = 1'b0;
`endif

endmodule

// File: tb/tb_sub_div4_ctrl.sv
// Self-checking bench for sub_div4_ctrl: arithmetic reference model, per-cycle compare, directed and random stimulus.
module tb_sub_div4_ctrl;

    localparam int W = 4;
`ifdef SUB_DIV_DZ_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       dz_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: busy cycles left, visible results, and results pending for the done cycle.
    int m_rem = 0;
    int m_q = 0;
    int m_r = 0;
    int m_dz = 0;
    int p_q = 0;
    int p_r = 0;
    int p_dz = 0;
    int ma = 0;
    int mb = 0;

    sub_div4_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz_err    (dz_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a division takes WIDTH+1 busy cycles (done in the last), or 1 cycle for a short-cut divide-by-zero.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_q = 0; m_r = 0; m_dz = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 1) begin
                m_q = p_q; m_r = p_r; m_dz = p_dz;
            end
        end else if (start) begin
            ma = int'(dividend);
            mb = int'(divisor);
            if (mb == 0) begin
                p_q = 15; p_r = ma; p_dz = int'(DZ_EN);
            end else begin
                p_q = ma / mb; p_r = ma % mb; p_dz = 0;
            end
            if (DZ_EN && mb == 0) begin
                m_rem = 1; m_q = p_q; m_r = p_r; m_dz = p_dz;
            end else begin
                m_rem = W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(m_rem > 0));
            check("done", int'(done), int'(m_rem == 1));
            check("quotient", int'(quotient), m_q);
            check("remainder", int'(remainder), m_r);
            check("dz_err", int'(dz_err), m_dz);
        end
    end

    // Called at an idle-cycle negedge; returns at the idle-cycle negedge after done.
    task automatic do_div(input int a, input int b, input int qe, input int re,
                          input int dze, input int late);
        int k;
        int busy_n;
        bit seen;
        k = 0; busy_n = 0; seen = 1'b0;
        start = 1'b1; dividend = 4'(a); divisor = 4'(b);
        for (int i = 1; i <= 12 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
            if (busy) busy_n++;
            if (done) begin seen = 1'b1; k = i; end
        end
        check("latency", k, late);
        check("busy_cycles", busy_n, late);
        check("q_lit", int'(quotient), qe);
        check("r_lit", int'(remainder), re);
        check("dz_lit", int'(dz_err), dze);
        @(negedge clk);
        check("busy_after", int'(busy), 0);
    endtask

    initial begin
        int eq, er, ed, el;
        bit seen;
        start = 1'b0; dividend = '0; divisor = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(quotient), 0);
        check("rst_r", int'(remainder), 0);
        check("rst_dz", int'(dz_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(13, 3, 4, 1, 0, 5);
        check("model_q_13_3", m_q, 4);
        check("model_r_13_3", m_r, 1);

        do_div(15, 1, 15, 0, 0, 5);
        do_div(7, 9, 0, 7, 0, 5);
        do_div(0, 5, 0, 0, 0, 5);
        do_div(15, 15, 1, 0, 0, 5);
        do_div(15, 9, 1, 6, 0, 5);
        do_div(14, 9, 1, 5, 0, 5);

        if (DZ_EN) begin
            do_div(11, 0, 15, 11, 1, 1);
            do_div(6, 2, 3, 0, 0, 5);
        end else begin
            do_div(11, 0, 15, 11, 0, 5);
        end

        // start held high with operands churning: only the first-sampled operands matter.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3; seen = 1'b0; el = 0;
        for (int i = 1; i <= 12 && !seen; i++) begin
            @(negedge clk);
            dividend = 4'($urandom); divisor = 4'($urandom);
            if (done) begin seen = 1'b1; el = i; end
        end
        check("held_latency", el, 5);
        check("held_q", int'(quotient), 4);
        check("held_r", int'(remainder), 1);
        @(negedge clk);
        check("held_idle_busy", int'(busy), 0);
        @(negedge clk);
        check("held_restart_busy", int'(busy), 1);
        start = 1'b0;
        for (int i = 0; i < 12 && busy; i++) @(negedge clk);
        check("held_drain", int'(busy), 0);

        // Reset after two iterations aborts with no done pulse.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_q", int'(quotient), 0);
        check("abort_r", int'(remainder), 0);
        check("abort_dz", int'(dz_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_div(9, 4, 2, 1, 0, 5);

        // Exhaustive operand sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 15; er = a; ed = int'(DZ_EN); el = DZ_EN ? 1 : 5;
                end else begin
                    eq = a / b; er = a % b; ed = 0; el = 5;
                end
                do_div(a, b, eq, er, ed, el);
            end
        end

        // Random starts, operands and occasional asynchronous resets.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            start = (($urandom % 3) == 0);
            dividend = 4'($urandom);
            divisor = 4'($urandom);
            if (($urandom % 150) == 0) begin
                #2 rst_n = 1'b0;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
